// File: rtl/fc_stream_driver_if.sv
// Valid/ready stream pair between the driver and an FC layer: tx carries x words out, rx carries y words back.
// master = driver side, slave = FC layer side.
interface fc_stream_driver_if #(
  parameter int WIDTH = 16
);
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] tx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [WIDTH-1:0] rx_data;

  modport master (
    output tx_valid, tx_data, rx_ready,
    input  tx_ready, rx_valid, rx_data
  );

  modport slave (
    input  tx_valid, tx_data, rx_ready,
    output tx_ready, rx_valid, rx_data
  );
endinterface

// File: rtl/fc_stream_driver.sv
// Sends an N-word x vector to an FC layer, collects M results, and reports ReLU violations and first-result latency.
// Registered control with no skid; tx stalls hold the word in place, and rx is accepted only while collecting.
module fc_stream_driver #(
  parameter int WIDTH = 16,
  parameter int N     = 6,
  parameter int M     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 host_wr_en,
  input  logic [$clog2(N)-1:0] host_wr_addr,
  input  logic [WIDTH-1:0]     host_wr_data,
  input  logic                 start,
  output logic                 busy,
  output logic                 done,
  fc_stream_driver_if.master   fc,
  input  logic [$clog2(M)-1:0] rd_addr,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 relu_err,
  output logic [15:0]          lat_cycles
);

  typedef enum logic [1:0] {IDLE, SEND, RECV, DONE} state_t;

  state_t state, state_nxt;

  logic [WIDTH-1:0]     xbuf [N];
  logic [WIDTH-1:0]     ybuf [M];
  logic [$clog2(N)-1:0] tx_cnt;
  logic [$clog2(M)-1:0] rx_cnt;

  logic tx_fire, rx_fire, tx_last, rx_last;

  assign tx_fire = fc.tx_valid && fc.tx_ready;
  assign rx_fire = fc.rx_valid && fc.rx_ready;
  assign tx_last = (32'(tx_cnt) == N - 1);
  assign rx_last = (32'(rx_cnt) == M - 1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = SEND;
      SEND:    if (tx_fire && tx_last) state_nxt = RECV;
      RECV:    if (rx_fire && rx_last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    fc.tx_valid = 1'b0;
    fc.rx_ready = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    fc.tx_data  = xbuf[tx_cnt];
    case (state)
      SEND: begin
        fc.tx_valid = 1'b1;
        busy        = 1'b1;
      end
      RECV: begin
        fc.rx_ready = 1'b1;
        busy        = 1'b1;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Counters wrap to 0 on the final transfer so they always index inside the buffers.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_cnt     <= '0;
      rx_cnt     <= '0;
      relu_err   <= 1'b0;
      lat_cycles <= '0;
      for (int i = 0; i < N; i++) xbuf[i] <= '0;
      for (int i = 0; i < M; i++) ybuf[i] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (host_wr_en && (32'(host_wr_addr) < N))
            xbuf[host_wr_addr] <= host_wr_data;
          if (start) begin
            tx_cnt     <= '0;
            rx_cnt     <= '0;
            relu_err   <= 1'b0;
            lat_cycles <= '0;
          end
        end
        SEND: begin
          if (tx_fire) tx_cnt <= tx_last ? '0 : tx_cnt + 1'b1;
        end
        RECV: begin
          // rx_cnt==0 means no result yet; the edge of the first transfer is still counted.
          if ((rx_cnt == '0) && (lat_cycles != 16'hFFFF))
            lat_cycles <= lat_cycles + 16'd1;
          if (rx_fire) begin
            ybuf[rx_cnt] <= fc.rx_data;
            if (fc.rx_data[WIDTH-1]) relu_err <= 1'b1;
            rx_cnt <= rx_last ? '0 : rx_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign rd_data = (32'(rd_addr) < M) ? ybuf[rd_addr] : '0;

endmodule

// File: tb/tb_fc_stream_driver.sv
// Directed bench for fc_stream_driver: send/stall/receive/ReLU/latency/mid-run reset scenarios.
module tb_fc_stream_driver;
  localparam int WIDTH = 16;
  localparam int N     = 6;
  localparam int M     = 8;

  logic        clk = 1'b0;
  logic        reset, host_wr_en, start;
  logic [2:0]  host_wr_addr, rd_addr;
  logic [15:0] host_wr_data, rd_data, lat_cycles;
  logic        busy, done, relu_err;

  int checks = 0;
  int errors = 0;

  logic [15:0] xv [N];
  logic [15:0] rv [M];

  always #5 clk = ~clk;

  fc_stream_driver_if #(.WIDTH(WIDTH)) sif();

  fc_stream_driver #(.WIDTH(WIDTH), .N(N), .M(M)) dut (
    .clk          (clk),
    .reset        (reset),
    .host_wr_en   (host_wr_en),
    .host_wr_addr (host_wr_addr),
    .host_wr_data (host_wr_data),
    .start        (start),
    .busy         (busy),
    .done         (done),
    .fc           (sif),
    .rd_addr      (rd_addr),
    .rd_data      (rd_data),
    .relu_err     (relu_err),
    .lat_cycles   (lat_cycles)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_x();
    for (int i = 0; i < N; i++) begin
      host_wr_en   = 1'b1;
      host_wr_addr = 3'(i);
      host_wr_data = xv[i];
      tick();
    end
    host_wr_en = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send_all();
    sif.tx_ready = 1'b1;
    repeat (N) tick();
    sif.tx_ready = 1'b0;
  endtask

  task automatic drain_rx();
    sif.rx_valid = 1'b1;
    sif.rx_data  = 16'h0;
    repeat (M) tick();
    sif.rx_valid = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy, done, sif.tx_valid, sif.rx_ready, relu_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got busy/done/txv/rxr/relu=%b required 00000",
               {busy, done, sif.tx_valid, sif.rx_ready, relu_err});
    end
    checks++;
    if (lat_cycles !== 16'h0) begin
      errors++;
      $display("FAIL reset_lat: got %0d required 0", lat_cycles);
    end
    for (int a = 0; a < M; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== 16'h0) begin
        errors++;
        $display("FAIL reset_ybuf[%0d]: got %h required 0000", a, rd_data);
      end
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_send();
    for (int i = 0; i < N; i++) xv[i] = 16'(i + 1);
    write_x();
    sif.tx_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sif.tx_valid !== 1'b1 || sif.tx_data !== 16'(i + 1) || busy !== 1'b1) begin
        errors++;
        $display("FAIL send_word%0d: got valid=%b data=%0d busy=%b required 1/%0d/1",
                 i, sif.tx_valid, sif.tx_data, busy, i + 1);
      end
      tick();
    end
    sif.tx_ready = 1'b0;
    checks++;
    if (sif.tx_valid !== 1'b0 || sif.rx_ready !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL send_to_recv: got txv=%b rxr=%b busy=%b required 0/1/1",
               sif.tx_valid, sif.rx_ready, busy);
    end
    drain_rx();
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || sif.rx_ready !== 1'b0) begin
      errors++;
      $display("FAIL send_idle: got busy=%b done=%b rxr=%b required 0/0/0", busy, done, sif.rx_ready);
    end
  endtask

  task automatic test_stall();
    int idx;
    for (int i = 0; i < N; i++) xv[i] = 16'h100 + 16'(7 * i);
    write_x();
    pulse_start();
    idx = 0;
    for (int c = 0; c < 40 && idx < N; c++) begin
      sif.tx_ready = (c % 3 == 0);
      start        = 1'b1;
      host_wr_en   = 1'b1;
      host_wr_addr = 3'(c % N);
      host_wr_data = 16'hDEAD;
      checks++;
      if (sif.tx_valid !== 1'b1 || sif.tx_data !== xv[idx]) begin
        errors++;
        $display("FAIL stall_c%0d: got valid=%b data=%h required 1/%h", c, sif.tx_valid, sif.tx_data, xv[idx]);
      end
      if (sif.tx_ready) idx++;
      tick();
    end
    start = 1'b0;
    host_wr_en = 1'b0;
    sif.tx_ready = 1'b0;
    checks++;
    if (idx != N || sif.tx_valid !== 1'b0 || sif.rx_ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_end: got sent=%0d txv=%b rxr=%b required %0d/0/1", idx, sif.tx_valid, sif.rx_ready, N);
    end
    drain_rx();
    // The same vector must come out again: busy-time writes were dropped.
    sif.tx_ready = 1'b1;
    pulse_start();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sif.tx_valid !== 1'b1 || sif.tx_data !== xv[i]) begin
        errors++;
        $display("FAIL repeat_word%0d: got valid=%b data=%h required 1/%h", i, sif.tx_valid, sif.tx_data, xv[i]);
      end
      tick();
    end
    sif.tx_ready = 1'b0;
    drain_rx();
  endtask

  task automatic test_recv();
    int dcount;
    dcount = 0;
    pulse_start();
    send_all();
    for (int i = 0; i < M; i++) begin
      sif.rx_valid = 1'b1;
      sif.rx_data  = 16'(10 + i);
      tick();
      sif.rx_valid = 1'b0;
      dcount += int'(done);
      if (i == 0) begin
        checks++;
        if (lat_cycles !== 16'd1) begin
          errors++;
          $display("FAIL recv_lat: got %0d required 1", lat_cycles);
        end
      end
      if (i == 2) begin
        rd_addr = 3'd2;
        #1;
        checks++;
        if (rd_data !== 16'd12) begin
          errors++;
          $display("FAIL recv_partial: got %0d required 12", rd_data);
        end
      end
      if (i < M - 1) begin
        tick();
        dcount += int'(done);
      end
    end
    checks++;
    if (done !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL recv_done: got done=%b busy=%b required 1/0", done, busy);
    end
    tick();
    dcount += int'(done);
    checks++;
    if (done !== 1'b0 || dcount != 1) begin
      errors++;
      $display("FAIL recv_pulse: got done=%b pulses=%0d required 0/1", done, dcount);
    end
    checks++;
    if (lat_cycles !== 16'd1) begin
      errors++;
      $display("FAIL recv_lat_frozen: got %0d required 1", lat_cycles);
    end
    for (int a = 0; a < M; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== 16'(10 + a)) begin
        errors++;
        $display("FAIL recv_ybuf[%0d]: got %0d required %0d", a, rd_data, 10 + a);
      end
    end
  endtask

  task automatic test_relu();
    rv = '{16'd1, 16'd2, 16'hFFFB, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
    pulse_start();
    send_all();
    for (int i = 0; i < M; i++) begin
      sif.rx_valid = 1'b1;
      sif.rx_data  = rv[i];
      tick();
      if (i == 1) begin
        checks++;
        if (relu_err !== 1'b0) begin
          errors++;
          $display("FAIL relu_early: got %b required 0", relu_err);
        end
      end
    end
    sif.rx_valid = 1'b0;
    tick();
    checks++;
    if (relu_err !== 1'b1) begin
      errors++;
      $display("FAIL relu_sticky: got %b required 1", relu_err);
    end
    rd_addr = 3'd2;
    #1;
    checks++;
    if (rd_data !== 16'hFFFB) begin
      errors++;
      $display("FAIL relu_ybuf2: got %h required fffb", rd_data);
    end
  endtask

  task automatic test_latency();
    pulse_start();
    checks++;
    if (relu_err !== 1'b0 || lat_cycles !== 16'd0) begin
      errors++;
      $display("FAIL lat_clear: got relu=%b lat=%0d required 0/0", relu_err, lat_cycles);
    end
    send_all();
    repeat (19) tick();
    checks++;
    if (lat_cycles !== 16'd19) begin
      errors++;
      $display("FAIL lat_wait: got %0d required 19", lat_cycles);
    end
    sif.rx_valid = 1'b1;
    sif.rx_data  = 16'h0;
    tick();
    checks++;
    if (lat_cycles !== 16'd20) begin
      errors++;
      $display("FAIL lat_first: got %0d required 20", lat_cycles);
    end
    repeat (M - 1) tick();
    sif.rx_valid = 1'b0;
    checks++;
    if (lat_cycles !== 16'd20 || done !== 1'b1) begin
      errors++;
      $display("FAIL lat_frozen: got lat=%0d done=%b required 20/1", lat_cycles, done);
    end
    tick();
  endtask

  task automatic test_mid_reset();
    sif.tx_ready = 1'b1;
    pulse_start();
    repeat (3) tick();
    checks++;
    if (sif.tx_valid !== 1'b1 || sif.tx_data !== xv[3]) begin
      errors++;
      $display("FAIL midrst_pre: got valid=%b data=%h required 1/%h", sif.tx_valid, sif.tx_data, xv[3]);
    end
    reset        = 1'b1;
    start        = 1'b1;
    host_wr_en   = 1'b1;
    host_wr_addr = 3'd0;
    host_wr_data = 16'h0055;
    tick();
    checks++;
    if ({sif.tx_valid, busy, sif.rx_ready, done} !== 4'b0) begin
      errors++;
      $display("FAIL midrst_ctrl: got txv/busy/rxr/done=%b required 0000",
               {sif.tx_valid, busy, sif.rx_ready, done});
    end
    reset      = 1'b0;
    start      = 1'b0;
    host_wr_en = 1'b0;
    for (int a = 0; a < M; a++) begin
      rd_addr = 3'(a);
      #1;
      checks++;
      if (rd_data !== 16'h0) begin
        errors++;
        $display("FAIL midrst_ybuf[%0d]: got %h required 0000", a, rd_data);
      end
    end
    pulse_start();
    for (int i = 0; i < N; i++) begin
      checks++;
      if (sif.tx_valid !== 1'b1 || sif.tx_data !== 16'h0) begin
        errors++;
        $display("FAIL midrst_word%0d: got valid=%b data=%h required 1/0000", i, sif.tx_valid, sif.tx_data);
      end
      tick();
    end
    sif.tx_ready = 1'b0;
    drain_rx();
  endtask

  initial begin
    reset        = 1'b1;
    host_wr_en   = 1'b0;
    host_wr_addr = 3'd0;
    host_wr_data = 16'h0;
    start        = 1'b0;
    rd_addr      = 3'd0;
    sif.tx_ready = 1'b0;
    sif.rx_valid = 1'b0;
    sif.rx_data  = 16'h0;

    test_reset();
    test_send();
    test_stall();
    test_recv();
    test_relu();
    test_latency();
    test_mid_reset();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
